// File: rtl/loopback_link_ctrl_pkg.sv
// rtl/loopback_link_ctrl_pkg.sv - shared types and lane constants for the loopback link controller
package loopback_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_WAIT_DLY  = 3'd2,
        ST_WAIT_VTC  = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_TRAIN     = 3'd5,
        ST_CHECK     = 3'd6
    } state_t;

    // pll_locked = {rx, tx, main}; dly_rdy/vtc_rdy = {rx bsc4..2, tx bsc4..3}
    localparam int PLL_LANES = 3;
    localparam int PLL_MAIN  = 0;
    localparam int PLL_TX    = 1;
    localparam int PLL_RX    = 2;
    localparam int RST_LANES = 2;
    localparam int BSC_LANES = 5;
    localparam int BSC_TX_LO = 0;
    localparam int BSC_RX_LO = 2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/loopback_link_ctrl_if.sv
// rtl/loopback_link_ctrl_if.sv - HPIO bring-up, FIFO and status bundle for the loopback controller
interface loopback_link_ctrl_if;
    import loopback_pkg::*;

    logic [PLL_LANES-1:0] pll_locked;
    logic [RST_LANES-1:0] rst_seq_done;
    logic [BSC_LANES-1:0] dly_rdy;
    logic [BSC_LANES-1:0] vtc_rdy;
    logic                 en_vtc;
    logic [3:0]           fifo_empty;
    logic                 fifo_rd_en;
    logic                 fifo_rd_data_valid;
    logic [7:0]           rx_data;
    logic [7:0]           tx_data;
    logic                 link_up;
    logic [2:0]           align_offset;
    logic                 align_fail;
    logic [CNT_W-1:0]     err_cnt;
    logic [CNT_W-1:0]     word_cnt;
    logic [2:0]           state;

    modport master (
        output pll_locked, rst_seq_done, dly_rdy, vtc_rdy, fifo_empty, fifo_rd_data_valid, rx_data,
        input  en_vtc, fifo_rd_en, tx_data, link_up, align_offset, align_fail, err_cnt, word_cnt, state
    );

    modport slave (
        input  pll_locked, rst_seq_done, dly_rdy, vtc_rdy, fifo_empty, fifo_rd_data_valid, rx_data,
        output en_vtc, fifo_rd_en, tx_data, link_up, align_offset, align_fail, err_cnt, word_cnt, state
    );

endinterface

// File: rtl/loopback_link_ctrl_word_aligner.sv
// rtl/loopback_link_ctrl_word_aligner.sv - 16-bit window, 8-way training compare, hit counter and offset latch
module word_aligner
    import loopback_pkg::*;
#(
    parameter logic [7:0] TRAIN_WORD = 8'h0F,
    parameter int         ALIGN_HITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift,
    input  logic       en,
    input  logic       clear,
    input  logic [7:0] rx_data,
    output logic       lock,
    output logic [2:0] offset,
    output logic [7:0] aligned
);

    localparam int HIT_W = $clog2(ALIGN_HITS + 1);

    logic [7:0]       rx_prev;
    logic [15:0]      window;
    logic [HIT_W-1:0] hit_cnt;
    logic [HIT_W-1:0] hit_nxt;
    logic [2:0]       hit_k;
    logic [2:0]       match_k;
    logic             match;

    assign window  = {rx_prev, rx_data};
    assign aligned = window[offset +: 8];

    // descending scan so the lowest matching offset wins
    always_comb begin
        match   = 1'b0;
        match_k = '0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == TRAIN_WORD) begin
                match   = 1'b1;
                match_k = 3'(k);
            end
        end
        if (!match)
            hit_nxt = '0;
        else if (hit_cnt != '0 && match_k == hit_k)
            hit_nxt = hit_cnt + 1'b1;
        else
            hit_nxt = HIT_W'(1);
    end

    assign lock = en && match && (hit_nxt == HIT_W'(ALIGN_HITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev <= '0;
            hit_cnt <= '0;
            hit_k   <= '0;
            offset  <= '0;
        end else begin
            if (shift)
                rx_prev <= rx_data;
            if (clear) begin
                hit_cnt <= '0;
            end else if (en) begin
                hit_cnt <= hit_nxt;
                hit_k   <= match_k;
            end
            if (lock)
                offset <= match_k;
        end
    end

endmodule

// File: rtl/loopback_link_ctrl.sv
// rtl/loopback_link_ctrl.sv - HPIO loopback bring-up FSM, counter pattern source and RX pattern checker
module loopback_link_ctrl
    import loopback_pkg::*;
#(
    parameter logic [7:0] TRAIN_WORD    = 8'h0F,
    parameter int         ALIGN_HITS    = 16,
    parameter int         ERR_LIMIT     = 4,
    parameter int         SETTLE_CYCLES = 64,
    parameter int         TRAIN_TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    loopback_link_ctrl_if.slave link
);

    localparam int SET_W   = $clog2(SETTLE_CYCLES);
    localparam int DWELL_W = $clog2(TRAIN_TIMEOUT);
    localparam int MIS_W   = $clog2(ERR_LIMIT + 1);

    state_t             state_q;
    state_t             state_d;
    logic [SET_W-1:0]   settle_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [MIS_W-1:0]   mism_cnt;
    logic [7:0]         expected;
    logic [7:0]         aligned;
    logic               seeded;
    logic               pll_ok;
    logic               dly_ok;
    logic               vtc_ok;
    logic               timeout;
    logic               lock;
    logic               chk_en;
    logic               mismatch;
    logic               drop;

    assign pll_ok = link.pll_locked[PLL_MAIN] & link.pll_locked[PLL_TX] & link.pll_locked[PLL_RX];
    assign dly_ok = (&link.dly_rdy[BSC_RX_LO-1:BSC_TX_LO]) & (&link.dly_rdy[BSC_LANES-1:BSC_RX_LO]);
    assign vtc_ok = (&link.vtc_rdy[BSC_RX_LO-1:BSC_TX_LO]) & (&link.vtc_rdy[BSC_LANES-1:BSC_RX_LO]);

    assign timeout  = (state_q == ST_TRAIN) && pll_ok && (dwell_cnt == DWELL_W'(TRAIN_TIMEOUT - 1));
    assign chk_en   = (state_q == ST_CHECK) && pll_ok && link.fifo_rd_data_valid;
    assign mismatch = aligned != expected;
    assign drop     = chk_en && seeded && mismatch && (mism_cnt == MIS_W'(ERR_LIMIT - 1));

    word_aligner #(
        .TRAIN_WORD (TRAIN_WORD),
        .ALIGN_HITS (ALIGN_HITS)
    ) u_aligner (
        .clk     (clk),
        .rst     (rst),
        .shift   (link.fifo_rd_data_valid && (state_q == ST_TRAIN || state_q == ST_CHECK)),
        .en      (link.fifo_rd_data_valid && pll_ok && state_q == ST_TRAIN),
        .clear   (state_q != ST_TRAIN || timeout),
        .rx_data (link.rx_data),
        .lock    (lock),
        .offset  (link.align_offset),
        .aligned (aligned)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: if (pll_ok && &link.rst_seq_done) state_d = ST_WAIT_DLY;
            ST_WAIT_DLY:  if (dly_ok) state_d = ST_WAIT_VTC;
            ST_WAIT_VTC:  if (vtc_ok) state_d = ST_SETTLE;
            ST_SETTLE:    if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state_d = ST_TRAIN;
            ST_TRAIN:     if (lock) state_d = ST_CHECK;
            ST_CHECK:     if (drop) state_d = ST_TRAIN;
            default:      state_d = ST_IDLE;
        endcase
        // PLL loss overrides every other transition
        if (state_q inside {ST_WAIT_DLY, ST_WAIT_VTC, ST_SETTLE, ST_TRAIN, ST_CHECK} && !pll_ok)
            state_d = ST_WAIT_LOCK;
    end

    assign link.state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            link.en_vtc     <= 1'b0;
            link.fifo_rd_en <= 1'b0;
            link.link_up    <= 1'b0;
            link.tx_data    <= TRAIN_WORD;
            link.align_fail <= 1'b0;
            link.err_cnt    <= '0;
            link.word_cnt   <= '0;
            settle_cnt      <= '0;
            dwell_cnt       <= '0;
            mism_cnt        <= '0;
            expected        <= '0;
            seeded          <= 1'b0;
        end else begin
            state_q         <= state_d;
            link.en_vtc     <= state_d inside {ST_WAIT_VTC, ST_SETTLE, ST_TRAIN, ST_CHECK};
            link.fifo_rd_en <= (state_d inside {ST_TRAIN, ST_CHECK}) && !(|link.fifo_empty);
            link.link_up    <= state_d == ST_CHECK;

            if (state_d != ST_CHECK)
                link.tx_data <= TRAIN_WORD;
            else if (state_q != ST_CHECK)
                link.tx_data <= 8'h00;
            else
                link.tx_data <= link.tx_data + 8'd1;

            settle_cnt <= (state_q == ST_SETTLE) ? settle_cnt + 1'b1 : '0;

            if (state_q != ST_TRAIN || timeout)
                dwell_cnt <= '0;
            else
                dwell_cnt <= dwell_cnt + 1'b1;
            if (timeout)
                link.align_fail <= 1'b1;

            // first valid word in CHECK only seeds the expected counter
            if (state_q != ST_CHECK) begin
                seeded   <= 1'b0;
                mism_cnt <= '0;
            end else if (chk_en) begin
                if (!seeded) begin
                    seeded   <= 1'b1;
                    expected <= aligned + 8'd1;
                end else begin
                    link.word_cnt <= sat_inc(link.word_cnt);
                    if (mismatch) begin
                        link.err_cnt <= sat_inc(link.err_cnt);
                        mism_cnt     <= mism_cnt + 1'b1;
                        expected     <= aligned + 8'd1;
                    end else begin
                        mism_cnt <= '0;
                        expected <= expected + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_loopback_link_ctrl.sv
// tb/tb_loopback_link_ctrl.sv - directed self-checking bench for loopback_link_ctrl
module tb_loopback_link_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] cur;

    always #5 clk = ~clk;

    loopback_link_ctrl_if link ();

    loopback_link_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // word carries cur in bits 7:3 and the top 3 bits of the next aligned word, i.e. a 3-bit skew
    task automatic send(input logic [7:0] nxt);
        link.rx_data            = {cur[4:0], nxt[7:5]};
        link.fifo_rd_data_valid = 1'b1;
        @(negedge clk);
        link.fifo_rd_data_valid = 1'b0;
        cur = nxt;
    endtask

    initial begin
        link.pll_locked         = '0;
        link.rst_seq_done       = '0;
        link.dly_rdy            = '0;
        link.vtc_rdy            = '0;
        link.fifo_empty         = '0;
        link.fifo_rd_data_valid = 1'b0;
        link.rx_data            = '0;
        cur                     = '0;

        @(negedge clk);
        chk("rst_state", link.state, 0);
        chk("rst_en_vtc", link.en_vtc, 0);
        chk("rst_rd_en", link.fifo_rd_en, 0);
        chk("rst_tx", link.tx_data, 8'h0F);
        chk("rst_link_up", link.link_up, 0);
        chk("rst_err", link.err_cnt, 0);
        rst = 1'b0;

        @(negedge clk);
        chk("wait_lock", link.state, 1);
        link.pll_locked = 3'b111;
        @(negedge clk);
        chk("hold_wait_lock", link.state, 1);
        link.rst_seq_done = 2'b11;
        @(negedge clk);
        chk("wait_dly", link.state, 2);
        chk("wait_dly_en_vtc", link.en_vtc, 0);
        link.dly_rdy = 5'h1F;
        @(negedge clk);
        chk("wait_vtc", link.state, 3);
        chk("wait_vtc_en_vtc", link.en_vtc, 1);
        link.vtc_rdy = 5'h1F;
        @(negedge clk);
        chk("settle", link.state, 4);
        repeat (63) @(negedge clk);
        chk("settle_63", link.state, 4);
        @(negedge clk);
        chk("train", link.state, 5);
        chk("train_rd_en", link.fifo_rd_en, 1);
        chk("train_tx", link.tx_data, 8'h0F);

        link.rx_data            = 8'h78;
        link.fifo_rd_data_valid = 1'b1;
        repeat (15) @(negedge clk);
        chk("align_15_link", link.link_up, 0);
        @(negedge clk);
        link.fifo_rd_data_valid = 1'b0;
        chk("align_16_state", link.state, 6);
        chk("align_16_link", link.link_up, 1);
        chk("align_offset", link.align_offset, 3);
        chk("check_tx0", link.tx_data, 8'h00);

        cur = 8'h00;
        for (int n = 1; n <= 2; n++) send(8'(n));
        chk("first_words", link.word_cnt, 1);
        chk("tx_count", link.tx_data, 8'h02);
        for (int n = 3; n <= 1000; n++) send(8'(n));
        chk("clean_err", link.err_cnt, 0);
        chk("clean_words", link.word_cnt, 999);

        send(cur + 8'h41);
        repeat (4) send(cur + 8'h01);
        chk("single_err", link.err_cnt, 1);
        chk("single_words", link.word_cnt, 1004);
        chk("single_link", link.link_up, 1);

        repeat (4) send(cur + 8'h41);
        chk("three_bad_link", link.link_up, 1);
        send(cur + 8'h41);
        chk("drop_link", link.link_up, 0);
        chk("drop_state", link.state, 5);
        chk("drop_tx", link.tx_data, 8'h0F);
        chk("drop_err", link.err_cnt, 5);
        chk("drop_words", link.word_cnt, 1009);

        for (int i = 0; i < 4095; i++) begin
            link.rx_data            = 8'($urandom);
            link.fifo_rd_data_valid = 1'b1;
            @(negedge clk);
        end
        chk("fail_before", link.align_fail, 0);
        @(negedge clk);
        chk("fail_after", link.align_fail, 1);
        chk("fail_state", link.state, 5);

        link.rx_data = 8'h78;
        for (int i = 0; i < 40 && link.link_up !== 1'b1; i++) @(negedge clk);
        link.fifo_rd_data_valid = 1'b0;
        chk("relock_link", link.link_up, 1);
        chk("relock_offset", link.align_offset, 3);
        chk("relock_tx0", link.tx_data, 8'h00);

        link.fifo_empty = 4'b0010;
        @(negedge clk);
        chk("fifo_empty_rd_en", link.fifo_rd_en, 0);
        link.fifo_empty = 4'b0000;
        repeat (299) @(negedge clk);
        chk("tx_wrap", link.tx_data, 8'h2C);
        chk("check_rd_en", link.fifo_rd_en, 1);
        chk("idle_words_held", link.word_cnt, 1009);

        link.pll_locked = 3'b101;
        @(negedge clk);
        chk("pll_loss_state", link.state, 1);
        chk("pll_loss_en_vtc", link.en_vtc, 0);
        chk("pll_loss_link", link.link_up, 0);
        chk("pll_loss_rd_en", link.fifo_rd_en, 0);
        chk("pll_loss_err", link.err_cnt, 5);
        chk("pll_loss_fail", link.align_fail, 1);

        link.pll_locked = 3'b111;
        for (int i = 0; i < 200 && link.state !== 3'd5; i++) @(negedge clk);
        chk("retrain", link.state, 5);
        link.rx_data            = 8'h78;
        link.fifo_rd_data_valid = 1'b1;
        for (int i = 0; i < 40 && link.link_up !== 1'b1; i++) @(negedge clk);
        link.fifo_rd_data_valid = 1'b0;
        chk("recheck", link.state, 6);

        #2 rst = 1'b1;
        #1;
        chk("arst_state", link.state, 0);
        chk("arst_en_vtc", link.en_vtc, 0);
        chk("arst_rd_en", link.fifo_rd_en, 0);
        chk("arst_tx", link.tx_data, 8'h0F);
        chk("arst_link", link.link_up, 0);
        chk("arst_offset", link.align_offset, 0);
        chk("arst_fail", link.align_fail, 0);
        chk("arst_err", link.err_cnt, 0);
        chk("arst_words", link.word_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_state", link.state, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
